// File: rtl/spike_collector_pkg.sv
// Shared types and defaults for the spike collector (state encoding, widths).
package spike_collector_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_N           = 256;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_DROP_W      = 16;

    // Class index width; a single class still needs one bit.
    function automatic int cls_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_collector_if.sv
// Spike pushback input and host result handshake bundle.
// SPIKE_COLLECTOR_IRQ_EN adds irq_o / irq_mask_i.
interface spike_collector_if
    import spike_collector_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DROP_W      = DEF_DROP_W
);
    localparam int AW = $clog2(N);
    localparam int IW = cls_w(NUM_CLASSES);

    logic              spike_pushback_i;
    logic [AW-1:0]     spike_pushback_addr_i;
    logic              inference_done_i;
    logic              result_valid_o;
    logic              result_ack_i;
    logic [IW-1:0]     winner_idx_o;
    logic [CNT_W-1:0]  winner_cnt_o;
    logic              no_spike_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              busy_o;
`ifdef SPIKE_COLLECTOR_IRQ_EN
    logic              irq_o;
    logic              irq_mask_i;
`endif

    modport master (
        output spike_pushback_i, spike_pushback_addr_i, inference_done_i, result_ack_i,
`ifdef SPIKE_COLLECTOR_IRQ_EN
        output irq_mask_i,
        input  irq_o,
`endif
        input  result_valid_o, winner_idx_o, winner_cnt_o, no_spike_o, drop_cnt_o, busy_o
    );

    modport slave (
        input  spike_pushback_i, spike_pushback_addr_i, inference_done_i, result_ack_i,
`ifdef SPIKE_COLLECTOR_IRQ_EN
        input  irq_mask_i,
        output irq_o,
`endif
        output result_valid_o, winner_idx_o, winner_cnt_o, no_spike_o, drop_cnt_o, busy_o
    );

endinterface

// File: rtl/spike_collector_sat_counter.sv
// Saturating up-counter; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i)           cnt_q <= '0;
        else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/spike_collector.sv
// Per-class spike counting, argmax scan on inference-done rise, valid/ack result.
// Optional SPIKE_COLLECTOR_IRQ_EN: one-cycle irq pulse on result, maskable.
module spike_collector
    import spike_collector_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DROP_W      = DEF_DROP_W
) (
    input logic              clk_i,
    input logic              rst_i,
    spike_collector_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int IW = cls_w(NUM_CLASSES);

    state_e                              state_q;
    logic                                done_q, busy_q, valid_q, no_spike_q;
    logic [IW-1:0]                       scan_idx_q, best_idx_q, winner_idx_q;
    logic [CNT_W-1:0]                    best_cnt_q, winner_cnt_q;
    logic [NUM_CLASSES-1:0][CNT_W-1:0]   cnt;
    logic [DROP_W-1:0]                   drop_cnt;

    logic             rise, accum, spk, ack_clr, gt, last;
    logic [CNT_W-1:0] cur_cnt, best_cnt_d;
    logic [IW-1:0]    best_idx_d;

    assign rise    = bus.inference_done_i & ~done_q;
    assign accum   = (state_q == ACCUM);
    assign spk     = bus.spike_pushback_i;
    assign ack_clr = (state_q == DONE) & bus.result_ack_i;

    // Addresses outside 0..NUM_CLASSES-1 match no counter and are silently ignored.
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cls
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (accum & spk & (bus.spike_pushback_addr_i == AW'(i))),
            .clr_i (ack_clr),
            .cnt_o (cnt[i])
        );
    end

    sat_counter #(.W(DROP_W)) u_drop (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (~accum & spk),
        .clr_i (ack_clr),
        .cnt_o (drop_cnt)
    );

    // Strictly-greater replace keeps the lowest index on ties.
    assign cur_cnt    = cnt[scan_idx_q];
    assign gt         = cur_cnt > best_cnt_q;
    assign best_cnt_d = gt ? cur_cnt : best_cnt_q;
    assign best_idx_d = gt ? scan_idx_q : best_idx_q;
    assign last       = (scan_idx_q == IW'(NUM_CLASSES - 1));

`ifdef SPIKE_COLLECTOR_IRQ_EN
    logic irq_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ACCUM;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            no_spike_q   <= 1'b0;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            winner_idx_q <= '0;
            winner_cnt_q <= '0;
`ifdef SPIKE_COLLECTOR_IRQ_EN
            irq_q        <= 1'b0;
`endif
        end else begin
            done_q <= bus.inference_done_i;
`ifdef SPIKE_COLLECTOR_IRQ_EN
            irq_q  <= 1'b0;
`endif
            case (state_q)
                ACCUM: if (rise) begin
                    state_q    <= SCAN;
                    busy_q     <= 1'b1;
                    scan_idx_q <= '0;
                    best_idx_q <= '0;
                    best_cnt_q <= '0;
                end
                SCAN: begin
                    scan_idx_q <= scan_idx_q + IW'(1);
                    best_idx_q <= best_idx_d;
                    best_cnt_q <= best_cnt_d;
                    if (last) begin
                        state_q      <= DONE;
                        valid_q      <= 1'b1;
                        winner_idx_q <= best_idx_d;
                        winner_cnt_q <= best_cnt_d;
                        no_spike_q   <= (best_cnt_d == '0);
`ifdef SPIKE_COLLECTOR_IRQ_EN
                        irq_q        <= ~bus.irq_mask_i;
`endif
                    end
                end
                DONE: if (bus.result_ack_i) begin
                    state_q <= ACCUM;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ACCUM;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result_valid_o = valid_q;
    assign bus.winner_idx_o   = winner_idx_q;
    assign bus.winner_cnt_o   = winner_cnt_q;
    assign bus.no_spike_o     = no_spike_q;
    assign bus.drop_cnt_o     = drop_cnt;
    assign bus.busy_o         = busy_q;
`ifdef SPIKE_COLLECTOR_IRQ_EN
    assign bus.irq_o          = irq_q;
`endif

endmodule

// File: tb/tb_spike_collector.sv
// Directed bench for spike_collector: table of inference vectors plus corner sequences.
module tb_spike_collector;
    import spike_collector_pkg::*;

    localparam int N  = 256;
    localparam int NC = 10;
    localparam int CW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spike_collector_if #(.N(N), .NUM_CLASSES(NC), .CNT_W(CW), .DROP_W(DW)) bus ();

    spike_collector #(.N(N), .NUM_CLASSES(NC), .CNT_W(CW), .DROP_W(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spikes(input int a, input int n);
        for (int k = 0; k < n; k++) begin
            bus.spike_pushback_i      = 1'b1;
            bus.spike_pushback_addr_i = a[7:0];
            tick();
        end
        bus.spike_pushback_i = 1'b0;
    endtask

    // Call with the rise already sampled; returns cycle index (rise cycle = 0) of first valid.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.result_valid_o && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic ack();
        bus.result_ack_i = 1'b1;
        tick();
        bus.result_ack_i = 1'b0;
    endtask

    typedef struct {
        int a0, n0, a1, n1, a2, n2;
        int e_idx, e_cnt, e_ns;
    } vec_t;

    vec_t vt [5];

    initial begin
        int cyc;
        int seen;

        vt[0] = '{a0: 3, n0: 5,   a1: 7, n1: 2,   a2: 200, n2: 4, e_idx: 3, e_cnt: 5,   e_ns: 0};
        vt[1] = '{a0: 2, n0: 300, a1: 5, n1: 300, a2: 0,   n2: 0, e_idx: 2, e_cnt: 255, e_ns: 0};
        vt[2] = '{a0: 0, n0: 0,   a1: 0, n1: 0,   a2: 0,   n2: 0, e_idx: 0, e_cnt: 0,   e_ns: 1};
        vt[3] = '{a0: 9, n0: 7,   a1: 0, n1: 7,   a2: 4,   n2: 6, e_idx: 0, e_cnt: 7,   e_ns: 0};
        vt[4] = '{a0: 9, n0: 8,   a1: 0, n1: 7,   a2: 10,  n2: 9, e_idx: 9, e_cnt: 8,   e_ns: 0};

        rst = 1'b1;
        bus.spike_pushback_i      = 1'b0;
        bus.spike_pushback_addr_i = '0;
        bus.inference_done_i      = 1'b0;
        bus.result_ack_i          = 1'b0;
`ifdef SPIKE_COLLECTOR_IRQ_EN
        bus.irq_mask_i            = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        chk("reset valid", bus.result_valid_o, 0);
        chk("reset busy", bus.busy_o, 0);
        chk("reset drop", bus.drop_cnt_o, 0);
        chk("reset no_spike", bus.no_spike_o, 0);
        chk("reset widx", bus.winner_idx_o, 0);
        chk("reset wcnt", bus.winner_cnt_o, 0);

        for (int v = 0; v < 5; v++) begin
            spikes(vt[v].a0, vt[v].n0);
            spikes(vt[v].a1, vt[v].n1);
            spikes(vt[v].a2, vt[v].n2);
            bus.inference_done_i = 1'b1;
            tick();
            wait_valid(cyc);
            chk($sformatf("v%0d latency", v), cyc, 11);
            chk($sformatf("v%0d widx", v), bus.winner_idx_o, vt[v].e_idx);
            chk($sformatf("v%0d wcnt", v), bus.winner_cnt_o, vt[v].e_cnt);
            chk($sformatf("v%0d no_spike", v), bus.no_spike_o, vt[v].e_ns);
            chk($sformatf("v%0d drop", v), bus.drop_cnt_o, 0);
            chk($sformatf("v%0d busy", v), bus.busy_o, 1);
            bus.inference_done_i = 1'b0;
            ack();
            chk($sformatf("v%0d valid after ack", v), bus.result_valid_o, 0);
            chk($sformatf("v%0d busy after ack", v), bus.busy_o, 0);
            chk($sformatf("v%0d widx held", v), bus.winner_idx_o, vt[v].e_idx);
        end

        // Drops during SCAN and DONE, ack with done still high, then no rescan.
        spikes(8, 3);
        bus.inference_done_i = 1'b1;
        tick();
        bus.spike_pushback_i      = 1'b1;
        bus.spike_pushback_addr_i = 8'd3;
        tick();
        tick();
        bus.spike_pushback_i = 1'b0;
        cyc = 3;
        while (!bus.result_valid_o && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("drop scan latency", cyc, 11);
        spikes(120, 2);
        chk("drop cnt", bus.drop_cnt_o, 4);
        chk("drop widx", bus.winner_idx_o, 8);
        chk("drop wcnt", bus.winner_cnt_o, 3);
        chk("drop valid held", bus.result_valid_o, 1);
        ack();
        chk("ack valid", bus.result_valid_o, 0);
        chk("ack drop clr", bus.drop_cnt_o, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy_o || bus.result_valid_o) seen = 1;
            tick();
        end
        chk("no retrigger", seen, 0);
        bus.inference_done_i = 1'b0;
        tick();
        bus.inference_done_i = 1'b1;
        tick();
        wait_valid(cyc);
        chk("cleared no_spike", bus.no_spike_o, 1);
        chk("cleared wcnt", bus.winner_cnt_o, 0);
        bus.inference_done_i = 1'b0;
        ack();

        // Spike in the rise cycle is counted; spike in the ack cycle is dropped then cleared.
        bus.spike_pushback_i      = 1'b1;
        bus.spike_pushback_addr_i = 8'd1;
        bus.inference_done_i      = 1'b1;
        tick();
        bus.spike_pushback_i = 1'b0;
        wait_valid(cyc);
        chk("simul widx", bus.winner_idx_o, 1);
        chk("simul wcnt", bus.winner_cnt_o, 1);
        bus.inference_done_i = 1'b0;
        bus.spike_pushback_i = 1'b1;
        ack();
        bus.spike_pushback_i = 1'b0;
        chk("ack-cycle drop", bus.drop_cnt_o, 0);
        chk("ack-cycle valid", bus.result_valid_o, 0);

        // Reset in scan cycle 4 aborts and clears counters.
        spikes(4, 10);
        bus.inference_done_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("midscan busy", bus.busy_o, 1);
        rst = 1'b1;
        bus.inference_done_i = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst busy", bus.busy_o, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.result_valid_o || bus.busy_o) seen = 1;
            tick();
        end
        chk("rst no valid", seen, 0);
        spikes(6, 3);
        bus.inference_done_i = 1'b1;
        tick();
        wait_valid(cyc);
        chk("post-rst latency", cyc, 11);
        chk("post-rst widx", bus.winner_idx_o, 6);
        chk("post-rst wcnt", bus.winner_cnt_o, 3);
        bus.inference_done_i = 1'b0;
        ack();

`ifdef SPIKE_COLLECTOR_IRQ_EN
        for (int m = 0; m < 2; m++) begin
            int pulses;
            int irq_first;
            pulses    = 0;
            irq_first = 0;
            seen      = 0;
            bus.irq_mask_i = m[0];
            spikes(5, 2);
            bus.inference_done_i = 1'b1;
            tick();
            for (int k = 0; k < 20; k++) begin
                if (bus.irq_o) pulses++;
                if (bus.result_valid_o && seen == 0) begin
                    seen      = 1;
                    irq_first = bus.irq_o;
                end
                tick();
            end
            chk($sformatf("irq m%0d pulses", m), pulses, (m == 0) ? 1 : 0);
            chk($sformatf("irq m%0d at first valid", m), irq_first, (m == 0) ? 1 : 0);
            bus.inference_done_i = 1'b0;
            ack();
        end
        bus.irq_mask_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
